// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sequencer sharing one register-file macro port between two requesters
module mem_port_arbiter #(
  parameter int DW = 52,
  parameter int AW = 7,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          mem_nce,
  output logic          mem_nwrt,
  output logic [AW-3:0] mem_ra,
  output logic [1:0]    mem_ca,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_do,
  output logic          busy
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RWAIT = 2'd2;
  logic [1:0] state, cnt;
  logic owner, op_rd, rr_ptr, sel, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  // sel: 0 = port A, 1 = port B; rr_ptr only matters on a tie
  assign sel = (a_req && b_req) ? rr_ptr : b_req;
  assign sel_we = sel ? b_we : a_we;
  assign sel_addr = sel ? b_addr : a_addr;
  assign sel_wdata = sel ? b_wdata : a_wdata;
  assign a_gnt = state == ACCESS && !owner;
  assign b_gnt = state == ACCESS && owner;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      state <= IDLE;
      cnt <= '0;
      owner <= 1'b0;
      op_rd <= 1'b0;
      rr_ptr <= 1'b0;
      mem_nce <= 1'b1;
      mem_nwrt <= 1'b1;
      mem_ra <= '0;
      mem_ca <= '0;
      mem_din <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state)
        IDLE:
          if (a_req || b_req) begin
            state <= ACCESS;
            mem_nce <= 1'b0;
            mem_nwrt <= ~sel_we;
            mem_ra <= sel_addr[AW-1:2];
            mem_ca <= sel_addr[1:0];
            mem_din <= sel_wdata;
            owner <= sel;
            op_rd <= ~sel_we;
          end
        ACCESS: begin
          mem_nce <= 1'b1;
          mem_nwrt <= 1'b1;
          rr_ptr <= ~owner;
          cnt <= 2'(RD_LAT - 1);
          state <= op_rd ? RWAIT : IDLE;
        end
        RWAIT:
          if (cnt == 2'd0) begin
            state <= IDLE;
            if (owner) begin
              b_rvalid <= 1'b1;
              b_rdata <= mem_do;
            end else begin
              a_rvalid <= 1'b1;
              a_rdata <= mem_do;
            end
          end else cnt <= cnt - 2'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, reset/alternation/latency corners and random traffic
module tb_mem_port_arbiter;
  localparam int DW = 52, AW = 7;
  logic clk = 1'b0, rstn = 1'b1;
  always #5 clk = ~clk;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0, a_rdata, b_rdata, mem_din, mem_do;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, mem_nce, mem_nwrt, busy;
  logic [AW-3:0] mem_ra;
  logic [1:0] mem_ca;
  logic a3_req = 0, a3_we = 0, b3_req = 0, b3_we = 0;
  logic [AW-1:0] a3_addr = '0, b3_addr = '0;
  logic [DW-1:0] a3_wdata = '0, b3_wdata = '0, a3_rdata, b3_rdata, mem_din3, mem_do3;
  logic a3_gnt, b3_gnt, a3_rvalid, b3_rvalid, mem_nce3, mem_nwrt3, busy3;
  logic [AW-3:0] mem_ra3;
  logic [1:0] mem_ca3;
  mem_port_arbiter #(.DW(DW), .AW(AW), .RD_LAT(1)) u1 (
    .clk(clk), .rstn(rstn),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_nce(mem_nce), .mem_nwrt(mem_nwrt), .mem_ra(mem_ra), .mem_ca(mem_ca),
    .mem_din(mem_din), .mem_do(mem_do), .busy(busy));
  mem_port_arbiter #(.DW(DW), .AW(AW), .RD_LAT(3)) u3 (
    .clk(clk), .rstn(rstn),
    .a_req(a3_req), .a_we(a3_we), .a_addr(a3_addr), .a_wdata(a3_wdata),
    .a_gnt(a3_gnt), .a_rvalid(a3_rvalid), .a_rdata(a3_rdata),
    .b_req(b3_req), .b_we(b3_we), .b_addr(b3_addr), .b_wdata(b3_wdata),
    .b_gnt(b3_gnt), .b_rvalid(b3_rvalid), .b_rdata(b3_rdata),
    .mem_nce(mem_nce3), .mem_nwrt(mem_nwrt3), .mem_ra(mem_ra3), .mem_ca(mem_ca3),
    .mem_din(mem_din3), .mem_do(mem_do3), .busy(busy3));

  int compared = 0, mismatched = 0;
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic logic [DW-1:0] junk();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Macro models: read data appears RD_LAT cycles after the access cycle, junk otherwise
  logic [DW-1:0] mem1 [128] = '{default: '0};
  logic [DW-1:0] mem3 [128] = '{default: '0};
  logic [DW-1:0] p1, p3 [3];
  always @(posedge clk) begin
    if (!mem_nce && !mem_nwrt) mem1[{mem_ra, mem_ca}] <= mem_din;
    p1 <= (!mem_nce && mem_nwrt) ? mem1[{mem_ra, mem_ca}] : junk();
    if (!mem_nce3 && !mem_nwrt3) mem3[{mem_ra3, mem_ca3}] <= mem_din3;
    p3[0] <= (!mem_nce3 && mem_nwrt3) ? mem3[{mem_ra3, mem_ca3}] : junk();
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_do = p1;
  assign mem_do3 = p3[2];

  // Transaction-level reference for u1: shadow memory, pending-read queue, last winner
  typedef struct {int due; bit port; logic [DW-1:0] data;} rd_t;
  rd_t q[$];
  logic [DW-1:0] shadow [128] = '{default: '0};
  bit last = 1'b1;
  bit [1:0] prev_req = '0;
  int cyc = 0, wait_a = 0, wait_b = 0;
  always @(negedge clk) begin : mon
    logic g, p, we, ea, eb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    if (rstn) begin
      q.delete();
      last = 1'b1;
      wait_a = 0;
      wait_b = 0;
    end else begin
      chk("one_gnt", a_gnt && b_gnt, 0);
      g = a_gnt || b_gnt;
      p = b_gnt;
      chk("nce_vs_gnt", mem_nce, !g);
      if (g) begin
        chk("gnt_had_req", p ? prev_req[1] : prev_req[0], 1);
        chk("rr_winner", p, (prev_req == 2'b11) ? !last : prev_req[1]);
        addr = p ? b_addr : a_addr;
        we = p ? b_we : a_we;
        wd = p ? b_wdata : a_wdata;
        chk("mon_ra", mem_ra, addr[AW-1:2]);
        chk("mon_ca", mem_ca, addr[1:0]);
        chk("mon_nwrt", mem_nwrt, !we);
        if (we) begin
          chk("mon_din", mem_din, wd);
          shadow[addr] = wd;
        end else q.push_back('{cyc + 2, p, shadow[addr]});
        last = p;
      end else chk("nwrt_idle", mem_nwrt, 1);
      ea = q.size() > 0 && q[0].due == cyc && !q[0].port;
      eb = q.size() > 0 && q[0].due == cyc && q[0].port;
      chk("a_rvalid", a_rvalid, ea);
      chk("b_rvalid", b_rvalid, eb);
      if (ea) chk("a_rdata", a_rdata, q[0].data);
      if (eb) chk("b_rdata", b_rdata, q[0].data);
      if (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      chk("busy", busy, g || q.size() > 0);
      wait_a = (a_req && !a_gnt) ? wait_a + 1 : 0;
      wait_b = (b_req && !b_gnt) ? wait_b + 1 : 0;
      chk("starve", wait_a > 8 || wait_b > 8, 0);
    end
    prev_req = {b_req, a_req};
    cyc++;
  end

  typedef struct {
    bit port; bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata;
    logic [DW-1:0] rdata; logic [AW-3:0] ra; logic [1:0] ca;
  } vec_t;
  vec_t vecs [7];

  task automatic run_vec(input vec_t v);
    bit got = 0;
    if (v.port) begin b_req = 1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata; end
    else begin a_req = 1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata; end
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = v.port ? b_gnt : a_gnt;
    end
    chk("vec_gnt", got, 1);
    chk("vec_ra", mem_ra, v.ra);
    chk("vec_ca", mem_ca, v.ca);
    chk("vec_nce", mem_nce, 0);
    chk("vec_nwrt", mem_nwrt, !v.we);
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    @(negedge clk);
    chk("vec_gnt_pulse", v.port ? b_gnt : a_gnt, 0);
    if (!v.we) begin
      chk("vec_rv_early", v.port ? b_rvalid : a_rvalid, 0);
      @(negedge clk);
      chk("vec_rvalid", v.port ? b_rvalid : a_rvalid, 1);
      chk("vec_rdata", v.port ? b_rdata : a_rdata, v.rdata);
      chk("vec_other_rv", v.port ? a_rvalid : b_rvalid, 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset();
    chk("rst_nce", mem_nce, 1);
    chk("rst_nwrt", mem_nwrt, 1);
    chk("rst_ra_ca_din", {mem_ra, mem_ca, mem_din}, 0);
    chk("rst_gnt_rv", {a_gnt, b_gnt, a_rvalid, b_rvalid, busy}, 0);
    chk("rst_rdata", a_rdata | b_rdata, 0);
  endtask

  initial begin #500000; $display("FAIL timeout"); $fatal(1); end

  initial begin
    int n;
    bit seq [4];
    bit ga, gb, got;
    vecs[0] = '{0, 1, 7'h05, 52'h0_0000_0000_ABCD, '0, 5'd1, 2'd1};
    vecs[1] = '{0, 0, 7'h05, '0, 52'h0_0000_0000_ABCD, 5'd1, 2'd1};
    vecs[2] = '{1, 1, 7'h7F, 52'hF_1234_5678_9ABC, '0, 5'd31, 2'd3};
    vecs[3] = '{0, 0, 7'h7F, '0, 52'hF_1234_5678_9ABC, 5'd31, 2'd3};
    vecs[4] = '{1, 0, 7'h05, '0, 52'h0_0000_0000_ABCD, 5'd1, 2'd1};
    vecs[5] = '{0, 1, 7'h00, 52'hF_FFFF_FFFF_FFFF, '0, 5'd0, 2'd0};
    vecs[6] = '{1, 0, 7'h00, '0, 52'hF_FFFF_FFFF_FFFF, 5'd0, 2'd0};
    @(negedge clk);
    check_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 0;
    foreach (vecs[i]) run_vec(vecs[i]);
    // reset while a read sits in RWAIT: data must be dropped silently
    a_req = 1; a_we = 0; a_addr = 7'h05;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin @(negedge clk); got = a_gnt; end
    chk("rw_gnt", got, 1);
    @(posedge clk); #1;
    a_req = 0; rstn = 1;
    @(negedge clk);
    check_reset();
    @(posedge clk); #1 rstn = 0;
    repeat (3) begin @(negedge clk); chk("rw_no_rvalid", a_rvalid || b_rvalid, 0); end
    @(posedge clk); #1;
    // both ports hold read requests: strict alternation starting with A
    a_req = 1; a_we = 0; a_addr = 7'h05;
    b_req = 1; b_we = 0; b_addr = 7'h7F;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_gnt || b_gnt) begin
        if (n < 4) seq[n] = b_gnt;
        n++;
      end
    end
    chk("rr_count", n, 4);
    for (int k = 0; k < 4; k++) chk("rr_order", seq[k], k % 2);
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ga = a_gnt; gb = b_gnt;
      @(posedge clk); #1;
      if (!a_req || ga) begin
        a_req = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
        a_addr = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom_range(0, 15));
        a_wdata = junk();
      end
      if (!b_req || gb) begin
        b_req = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
        b_addr = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom_range(0, 15));
        b_wdata = junk();
      end
    end
    @(negedge clk);
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    repeat (6) @(posedge clk);
    #1;
    // RD_LAT=3: read returns at gnt+4, B arriving mid-wait is granted right after
    a3_req = 1; a3_we = 1; a3_addr = 7'h10; a3_wdata = 52'h5_A5A5_0F0F_1234;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin @(negedge clk); got = a3_gnt; end
    chk("l3_wr_gnt", got, 1);
    @(posedge clk); #1;
    a3_we = 0;
    @(negedge clk);
    chk("l3_wr_gnt_pulse", a3_gnt, 0);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin @(negedge clk); got = a3_gnt; end
    chk("l3_rd_gnt", got, 1);
    @(posedge clk); #1 a3_req = 0;
    @(negedge clk);
    chk("l3_rv_t1", a3_rvalid, 0);
    @(posedge clk); #1;
    b3_req = 1; b3_we = 0; b3_addr = 7'h10;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk("l3_a_rvalid", a3_rvalid, k == 4);
      chk("l3_b_early", b3_gnt, 0);
    end
    chk("l3_a_rdata", a3_rdata, 52'h5_A5A5_0F0F_1234);
    @(negedge clk);
    chk("l3_b_gnt", b3_gnt, 1);
    @(posedge clk); #1 b3_req = 0;
    for (int k = 6; k <= 9; k++) begin
      @(negedge clk);
      chk("l3_b_rvalid", b3_rvalid, k == 9);
    end
    chk("l3_b_rdata", b3_rdata, 52'h5_A5A5_0F0F_1234);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
